imem_fetch_unit: RTL and testbench

Instruction fetch front end for the MIPS core. It reads the byte-wide, big-endian instruction memory one byte per cycle and assembles each 32-bit instruction word. Each completed word goes into a small prefetch queue, which the decode/execute stage drains through a valid/ready handshake. PC redirects from the core (taken branch, j/jal, jr) flush the queue and restart fetch at the new address.

---
 rtl/imem_fetch_if.sv | 23 ++
 rtl/imem_fetch_unit.sv | 124 ++++++++++++
 tb/tb_imem_fetch_unit.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_fetch_if.sv
// Fetch-unit bus bundle: byte-wide instruction memory port plus the
// decoded-instruction valid/ready stream towards decode/execute.
interface imem_fetch_if #(
  parameter int ADDR_W = 5
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              inst_valid;
  logic [31:0]       inst;
  logic [31:0]       inst_pc;
  logic              inst_ready;

  modport master (
    output mem_rd, mem_addr, inst_valid, inst, inst_pc,
    input  mem_rdata, inst_ready
  );

  modport slave (
    input  mem_rd, mem_addr, inst_valid, inst, inst_pc,
    output mem_rdata, inst_ready
  );
endinterface

// File: rtl/imem_fetch_unit.sv
// Instruction fetch front end: assembles big-endian 32-bit words from a
// byte-wide memory (one byte per cycle) into a small prefetch queue.
module imem_fetch_unit #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] fetch_pc,
  imem_fetch_if.master bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t            state_reg, state_next;
  logic [1:0]        k_reg, k_next;
  logic [31:0]       fetch_pc_reg, fetch_pc_next;
  logic [23:0]       shift_reg, shift_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [PTR_W-1:0]  head_reg, head_next;
  logic [PTR_W-1:0]  tail_reg, tail_next;
  logic [31:0]       q_inst_reg [DEPTH];
  logic [31:0]       q_pc_reg   [DEPTH];

  logic              push;
  logic              pop;
  logic              start_ok;
  logic [CNT_W-1:0]  occ_after;
  logic [31:0]       word;

  // Last byte comes straight off the memory bus during DRAIN.
  assign word = {shift_reg, bus.mem_rdata};

  always_comb begin
    state_next    = state_reg;
    k_next        = k_reg;
    fetch_pc_next = fetch_pc_reg;
    shift_next    = shift_reg;
    head_next     = head_reg;
    tail_next     = tail_reg;

    pop       = (count_reg != '0) && bus.inst_ready && !redirect;
    push      = (state_reg == DRAIN) && !redirect;
    occ_after = count_reg + CNT_W'(push) - CNT_W'(pop);
    start_ok  = occ_after < DEPTH_C;

    case (state_reg)
      IDLE: begin
        if (start_ok) begin
          state_next = ISSUE;
          k_next     = '0;
        end
      end
      ISSUE: begin
        if (k_reg != 2'd0) shift_next = {shift_reg[15:0], bus.mem_rdata};
        if (k_reg == 2'd3) state_next = DRAIN;
        else               k_next     = k_reg + 2'd1;
      end
      DRAIN: begin
        fetch_pc_next = fetch_pc_reg + 32'd4;
        k_next        = '0;
        state_next    = start_ok ? ISSUE : IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (push) tail_next = tail_reg + PTR_W'(1);
    if (pop)  head_next = head_reg + PTR_W'(1);
    count_next = occ_after;

    // Redirect flushes everything; the byte still in flight is ignored
    // because ISSUE k=0 never captures.
    if (redirect) begin
      state_next    = ISSUE;
      k_next        = '0;
      fetch_pc_next = redirect_pc;
      count_next    = '0;
      head_next     = '0;
      tail_next     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ISSUE;
      k_reg        <= '0;
      fetch_pc_reg <= '0;
      shift_reg    <= '0;
      count_reg    <= '0;
      head_reg     <= '0;
      tail_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      k_reg        <= k_next;
      fetch_pc_reg <= fetch_pc_next;
      shift_reg    <= shift_next;
      count_reg    <= count_next;
      head_reg     <= head_next;
      tail_reg     <= tail_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      q_inst_reg[tail_reg] <= word;
      q_pc_reg[tail_reg]   <= fetch_pc_reg;
    end
  end

  // Start-pending after reset: the FSM sits in ISSUE k=0 but the request
  // is held off until rst drops.
  assign bus.mem_rd   = (state_reg == ISSUE) && !rst;
  assign bus.mem_addr = bus.mem_rd ? (fetch_pc_reg[ADDR_W-1:0] + ADDR_W'(k_reg)) : '0;

  assign bus.inst_valid = (count_reg != '0);
  assign bus.inst       = bus.inst_valid ? q_inst_reg[head_reg] : '0;
  assign bus.inst_pc    = bus.inst_valid ? q_pc_reg[head_reg]   : '0;
  assign fetch_pc       = fetch_pc_reg;
endmodule

// File: tb/tb_imem_fetch_unit.sv
// Self-checking bench for imem_fetch_unit: directed timing scenarios plus a
// randomized redirect/backpressure phase checked by a scoreboard.
module tb_imem_fetch_unit;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] fetch_pc;

  imem_fetch_if #(.ADDR_W(ADDR_W)) bus();

  imem_fetch_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fetch_pc    (fetch_pc),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Byte memory with one-cycle read latency.
  logic [7:0] mem [32];
  always @(posedge clk) if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   xfers  = 0;

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    logic [4:0] a;
    a = pc[4:0];
    return {mem[a], mem[a + 5'd1], mem[a + 5'd2], mem[a + 5'd3]};
  endfunction

  // The consumer must see pc, pc+4, pc+8, ... after any restart.
  task automatic expect_stream(input logic [31:0] pc, input int n);
    exp_t e;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      e.pc   = pc + 32'(4 * i);
      e.inst = word_at(e.pc);
      exp_q.push_back(e);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    chk("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_inst", bus.inst, 32'd0);
    chk("rst_inst_pc", bus.inst_pc, 32'd0);
    chk("rst_fetch_pc", fetch_pc, 32'd0);
  endtask

  // One reset cycle, then return positioned in cycle 0 (inputs applied).
  task automatic start(input logic rdy);
    step();
    rst = 1'b1;
    redirect = 1'b0;
    exp_q.delete();
    step();
    expect_stream(32'd0, 16);
    rst = 1'b0;
    bus.inst_ready = rdy;
  endtask

  // Scoreboard monitor: pops on every accepted word, checks head stability.
  exp_t        mon_e;
  logic        stall_prev = 1'b0;
  logic [31:0] stall_inst, stall_pc;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && !redirect) begin
        if (stall_prev) begin
          chk("hold_valid", 32'(bus.inst_valid), 32'd1);
          chk("hold_inst", bus.inst, stall_inst);
          chk("hold_pc", bus.inst_pc, stall_pc);
        end
        if (bus.inst_valid && bus.inst_ready) begin
          xfers++;
          $display("xfer %0d pc=%h inst=%h", xfers, bus.inst_pc, bus.inst);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_extra: got pc %h, want no transfer", bus.inst_pc);
          end else begin
            mon_e = exp_q.pop_front();
            chk("sb_inst", bus.inst, mon_e.inst);
            chk("sb_pc", bus.inst_pc, mon_e.pc);
          end
        end
        stall_prev = bus.inst_valid && !bus.inst_ready;
        stall_inst = bus.inst;
        stall_pc   = bus.inst_pc;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  initial begin
    int n;
    logic [31:0] pc;
    for (int i = 0; i < 32; i++) mem[i] = 8'(i);
    bus.inst_ready = 1'b1;

    step();
    step();
    #1;
    check_reset_outputs();

    // Basic fetch with an always-ready consumer.
    start(1'b1);
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) step();
      #1;
      chk("basic_mem_rd", 32'(bus.mem_rd), 32'((c % 5) != 4));
      if ((c % 5) != 4) chk("basic_mem_addr", 32'(bus.mem_addr), 32'((c / 5) * 4 + (c % 5)));
      if (c < 5) chk("basic_early_valid", 32'(bus.inst_valid), 32'd0);
      if (c == 5) begin
        chk("basic_valid5", 32'(bus.inst_valid), 32'd1);
        chk("basic_inst5", bus.inst, 32'h0001_0203);
        chk("basic_pc5", bus.inst_pc, 32'd0);
      end
      if (c == 10) begin
        chk("basic_inst10", bus.inst, 32'h0405_0607);
        chk("basic_pc10", bus.inst_pc, 32'd4);
      end
    end

    // Backpressure: queue fills, fetch stops, a single pop restarts it.
    start(1'b0);
    for (int c = 0; c <= 16; c++) begin
      if (c > 0) step();
      bus.inst_ready = (c == 15);
      #1;
      if (c >= 9 && c <= 14) chk("bp_idle_mem_rd", 32'(bus.mem_rd), 32'd0);
      if (c == 12) begin
        chk("bp_full_valid", 32'(bus.inst_valid), 32'd1);
        chk("bp_head_pc", bus.inst_pc, 32'd0);
      end
      if (c == 16) begin
        chk("bp_next_head", bus.inst_pc, 32'd4);
        chk("bp_restart_rd", 32'(bus.mem_rd), 32'd1);
        chk("bp_restart_addr", 32'(bus.mem_addr), 32'd8);
        chk("bp_fetch_pc", fetch_pc, 32'd8);
      end
    end

    // Redirect mid-fetch, then a redirect that wraps the byte address.
    start(1'b1);
    for (int c = 0; c <= 15; c++) begin
      if (c > 0) step();
      redirect    = (c == 2) || (c == 9);
      redirect_pc = (c == 2) ? 32'h10 : 32'h1E;
      if (c == 2) expect_stream(32'h10, 16);
      if (c == 9) expect_stream(32'h1E, 16);
      #1;
      if (c == 3) begin
        chk("rd_flush_valid", 32'(bus.inst_valid), 32'd0);
        chk("rd_issue_addr", 32'(bus.mem_addr), 32'h10);
        chk("rd_fetch_pc", fetch_pc, 32'h10);
      end
      if (c == 8) begin
        chk("rd_inst", bus.inst, 32'h1011_1213);
        chk("rd_pc", bus.inst_pc, 32'h10);
      end
      if (c == 15) begin
        chk("wrap_inst", bus.inst, 32'h1E1F_0001);
        chk("wrap_pc", bus.inst_pc, 32'h1E);
        chk("wrap_fetch_pc", fetch_pc, 32'h22);
        chk("wrap_mem_addr", 32'(bus.mem_addr), 32'h02);
        chk("wrap_mem_rd", 32'(bus.mem_rd), 32'd1);
      end
    end

    // Redirect, pop and DRAIN push all in cycle 9.
    start(1'b0);
    for (int c = 0; c <= 15; c++) begin
      if (c > 0) step();
      redirect       = (c == 9);
      redirect_pc    = 32'h14;
      bus.inst_ready = (c >= 9);
      if (c == 9) expect_stream(32'h14, 16);
      #1;
      if (c == 10) chk("sim_empty", 32'(bus.inst_valid), 32'd0);
      if (c == 15) begin
        chk("sim_valid", 32'(bus.inst_valid), 32'd1);
        chk("sim_inst", bus.inst, 32'h1415_1617);
        chk("sim_pc", bus.inst_pc, 32'h14);
      end
    end

    // Reset during DRAIN with one word queued.
    start(1'b0);
    for (int c = 1; c <= 9; c++) step();
    rst = 1'b1;
    exp_q.delete();
    step();
    #1;
    check_reset_outputs();
    step();
    rst = 1'b0;
    bus.inst_ready = 1'b1;
    expect_stream(32'd0, 16);
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) step();
      #1;
      if (c < 5) chk("rr_early_valid", 32'(bus.inst_valid), 32'd0);
      else begin
        chk("rr_inst", bus.inst, 32'h0001_0203);
        chk("rr_pc", bus.inst_pc, 32'd0);
      end
    end

    // Random phase: random memory, random redirects and consumer stalls.
    step();
    rst = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    step();
    rst = 1'b0;
    for (int seg = 0; seg < 20; seg++) begin
      step();
      if (seg == 0)      pc = 32'hFFFF_FFFC;
      else if (seg == 1) pc = 32'h0000_001D;
      else               pc = $urandom;
      redirect       = 1'b1;
      redirect_pc    = pc;
      bus.inst_ready = 1'($urandom_range(0, 1));
      expect_stream(pc, 16);
      for (int j = 1; j <= 6; j++) begin
        step();
        redirect       = 1'b0;
        bus.inst_ready = 1'($urandom_range(0, 1));
        #1;
        chk("redir_latency", 32'(bus.inst_valid), 32'(j == 6));
      end
      n = $urandom_range(5, 50);
      for (int j = 0; j < n; j++) begin
        step();
        bus.inst_ready = ($urandom_range(0, 3) != 0);
      end
    end

    step();
    bus.inst_ready = 1'b1;
    for (int j = 0; j < 10; j++) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
